// File: rtl/fsm_seq_pkg.sv
// Shared constants, datapath state codes and sequencer state type for the
// nibble-serial operation sequencer.
package fsm_seq_pkg;

  localparam int unsigned N         = 64;
  localparam int unsigned NW        = 4;
  localparam int unsigned NUM_LANES = N / NW;
  localparam int unsigned LIW       = $clog2(NUM_LANES);
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned LW        = AW + 1;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned TW        = $clog2(TIMEOUT + 1);

  localparam logic [1:0] DRAIN_OP = 2'd1;

  localparam logic [3:0] DP_S0     = 4'd0;
  localparam logic [3:0] DP_S1     = 4'd1;
  localparam logic [3:0] DP_S2     = 4'd2;
  localparam logic [3:0] DP_S3     = 4'd3;
  localparam logic [3:0] DP_S4     = 4'd4;
  localparam logic [3:0] DP_S5     = 4'd5;
  localparam logic [3:0] DP_S6     = 4'd6;
  localparam logic [3:0] DP_S7     = 4'd7;
  localparam logic [3:0] DP_IDLE   = 4'd8;
  localparam logic [3:0] DP_INPUT  = 4'd9;
  localparam logic [3:0] DP_OUTPUT = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    RUN,
    DRAIN,
    COLLECT,
    DONE
  } seq_state_t;

  // Program lengths beyond the memory depth run the whole program.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    return (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/fsm_seq_prog_mem.sv
// Op program register file: one synchronous write port, one async read port.
module fsm_seq_prog_mem
  import fsm_seq_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata_c
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/fsm_op_sequencer.sv
// Host-side sequencer: loads operands into the nibble-serial datapath, runs
// the op program, drains until OUTPUT and reassembles the 64-bit result.
module fsm_op_sequencer
  import fsm_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [1:0]    cfg_op,
  input  logic [LW-1:0] prog_len,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [N-1:0]  result,
  output logic          dp_start,
  output logic          dp_input_enable,
  output logic [NW-1:0] dp_a,
  output logic [NW-1:0] dp_b,
  output logic [1:0]    dp_op_val,
  input  logic [3:0]    dp_state_res,
  input  logic          dp_output_valid,
  input  logic [NW-1:0] dp_out
);

  seq_state_t     state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, result_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LIW-1:0] li_q, li_d, ci_q, ci_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           terr_d;
  logic           capture, last_lane;
  logic           prog_we_c;
  logic [1:0]     prog_rdata_c;

  assign prog_we_c = cfg_we && (state_q == IDLE);

  fsm_seq_prog_mem u_prog (
    .clk     (clk),
    .we      (prog_we_c),
    .waddr   (cfg_addr),
    .wdata   (cfg_op),
    .raddr   (pc_q),
    .rdata_c (prog_rdata_c)
  );

  // Next-state, counters and result capture.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    len_d     = len_q;
    li_d      = li_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    ci_d      = ci_q;
    result_d  = result;
    terr_d    = timeout_err;
    capture   = dp_output_valid &&
                ((state_q == RUN) || (state_q == DRAIN) || (state_q == COLLECT));
    last_lane = capture && (ci_q == LIW'(NUM_LANES - 1));

    if (capture) begin
      result_d[NW*ci_q +: NW] = dp_out;
      ci_d = ci_q + LIW'(1);
    end

    case (state_q)
      IDLE: begin
        if (go) begin
          a_d      = a_in;
          b_d      = b_in;
          len_d    = clamp_len(prog_len);
          result_d = '0;
          terr_d   = 1'b0;
          li_d     = '0;
          pc_d     = '0;
          cnt_d    = '0;
          ci_d     = '0;
          state_d  = START;
        end
      end
      START: begin
        if (dp_state_res == DP_INPUT) begin
          li_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        li_d = li_q + LIW'(1);
        if (li_q == LIW'(NUM_LANES - 1)) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = (len_q == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (last_lane) begin
          state_d = DONE;
        end else if (dp_state_res == DP_OUTPUT) begin
          state_d = COLLECT;
        end else if ({1'b0, pc_q} == len_q - LW'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          pc_d = pc_q + AW'(1);
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + TW'(1);
        if (last_lane) begin
          state_d = DONE;
        end else if (dp_state_res == DP_OUTPUT) begin
          state_d = COLLECT;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      COLLECT: begin
        if (last_lane) begin
          state_d = DONE;
        end else if (!dp_output_valid) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath registers and registered outputs derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      a_q             <= '0;
      b_q             <= '0;
      len_q           <= '0;
      li_q            <= '0;
      pc_q            <= '0;
      cnt_q           <= '0;
      ci_q            <= '0;
      result          <= '0;
      timeout_err     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dp_start        <= 1'b0;
      dp_input_enable <= 1'b0;
      dp_a            <= '0;
      dp_b            <= '0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      b_q             <= b_d;
      len_q           <= len_d;
      li_q            <= li_d;
      pc_q            <= pc_d;
      cnt_q           <= cnt_d;
      ci_q            <= ci_d;
      result          <= result_d;
      timeout_err     <= terr_d;
      busy            <= (state_d != IDLE);
      done            <= (state_d == DONE);
      dp_start        <= (state_d == START);
      dp_input_enable <= (state_d == LOAD);
      dp_a            <= (state_d == LOAD) ? a_q[NW*li_d +: NW] : '0;
      dp_b            <= (state_d == LOAD) ? b_q[NW*li_d +: NW] : '0;
    end
  end

  // Op select is squashed the same cycle OUTPUT is seen so no stale entry leaks out.
  always_comb begin
    dp_op_val = 2'd0;
    if (dp_state_res != DP_OUTPUT) begin
      if (state_q == RUN)        dp_op_val = prog_rdata_c;
      else if (state_q == DRAIN) dp_op_val = DRAIN_OP;
    end
  end

endmodule
